// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths and the round-key slice helper
package aes_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int ARK_RND_W     = 4;
  localparam int AES_NR_MAX    = 14;
  localparam int AES_KEY_MAX_W = AES_BLK_W * (AES_NR_MAX + 1);

  // key is the expanded key right-aligned in the widest bus; round 0 is the top slice
  function automatic logic [AES_BLK_W-1:0] ark_key_sel(
    input logic [AES_KEY_MAX_W-1:0] key,
    input logic [ARK_RND_W-1:0]     r,
    input int                       nr
  );
    return key[AES_BLK_W * (nr - int'(r)) +: AES_BLK_W];
  endfunction

endpackage

// File: rtl/ark_lane.sv
// rtl/ark_lane.sv - one 128-bit AddRoundKey lane
module ark_lane
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state,
  input  logic [AES_BLK_W-1:0] round_key,
  output logic [AES_BLK_W-1:0] result
);

  assign result = state ^ round_key;

endmodule

// File: rtl/addroundkey_stage.sv
// rtl/addroundkey_stage.sv - registered handshaked AddRoundKey stage with auto/manual round select
// ARK_ROUND_CHECK_EN adds out_err and passes out-of-range rounds through unmodified
module addroundkey_stage
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int LANES = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           round_auto,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [AES_BLK_W*LANES-1:0]     in_state,
  input  logic [ARK_RND_W-1:0]           in_round,
  input  logic                           in_first,
  input  logic [AES_BLK_W*(NR+1)-1:0]    key,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [AES_BLK_W*LANES-1:0]     out_state,
  output logic [ARK_RND_W-1:0]           out_round,
  output logic                           out_last
`ifdef ARK_ROUND_CHECK_EN
  ,
  output logic                           out_err
`endif
);

  localparam int                   W      = AES_BLK_W * LANES;
  localparam logic [ARK_RND_W-1:0] NR_IDX = ARK_RND_W'(NR);

  logic [ARK_RND_W-1:0]     cnt;
  logic [ARK_RND_W-1:0]     r_sel;
  logic [ARK_RND_W-1:0]     r_key;
  logic                     over;
  logic                     accept;
  logic [AES_KEY_MAX_W-1:0] key_ext;
  logic [AES_BLK_W-1:0]     round_key;
  logic [W-1:0]             xored;
  logic [W-1:0]             state_d;
  logic [ARK_RND_W-1:0]     round_d;
  logic                     last_d;
`ifdef ARK_ROUND_CHECK_EN
  logic                     err_d;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign key_ext  = AES_KEY_MAX_W'(key);

  // the counter never exceeds NR, so only manual rounds can be out of range
  always_comb begin
    r_sel = round_auto ? (in_first ? '0 : cnt) : in_round;
    over  = r_sel > NR_IDX;
    r_key = over ? NR_IDX : r_sel;
  end

  assign round_key = ark_key_sel(key_ext, r_key, NR);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ark_lane u_lane (
      .state     (in_state[AES_BLK_W*k +: AES_BLK_W]),
      .round_key (round_key),
      .result    (xored[AES_BLK_W*k +: AES_BLK_W])
    );
  end

  always_comb begin
    state_d = xored;
    round_d = r_key;
    last_d  = (r_key == NR_IDX);
`ifdef ARK_ROUND_CHECK_EN
    err_d   = 1'b0;
    if (over) begin
      state_d = in_state;
      round_d = in_round;
      last_d  = 1'b0;
      err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_state <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
      cnt       <= '0;
`ifdef ARK_ROUND_CHECK_EN
      out_err   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_state <= state_d;
        out_round <= round_d;
        out_last  <= last_d;
`ifdef ARK_ROUND_CHECK_EN
        out_err   <= err_d;
`endif
        if (round_auto) begin
          cnt <= (r_sel == NR_IDX) ? '0 : r_sel + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addroundkey_stage.sv
// tb/tb_addroundkey_stage.sv - scoreboard bench for addroundkey_stage (NR=10, LANES=2)
module tb_addroundkey_stage;

  localparam int NR    = 10;
  localparam int LANES = 2;
  localparam int W     = 128 * LANES;
  localparam int KW    = 128 * (NR + 1);

  typedef struct {
    logic [W-1:0] state;
    logic [3:0]   round;
    logic         last;
    logic         err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          round_auto;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_state;
  logic [3:0]    in_round;
  logic          in_first;
  logic [KW-1:0] key;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_state;
  logic [3:0]    out_round;
  logic          out_last;
`ifdef ARK_ROUND_CHECK_EN
  logic          out_err;
`endif

  logic [127:0] rk [0:NR];
  exp_t         exp_q[$];
  int           n_vec  = 0;
  int           n_fail = 0;
  logic         rand_mode   = 1'b0;
  logic         ready_force = 1'b1;

  addroundkey_stage #(.NR(NR), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .round_auto (round_auto),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .in_round   (in_round),
    .in_first   (in_first),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .out_round  (out_round),
    .out_last   (out_last)
`ifdef ARK_ROUND_CHECK_EN
    ,
    .out_err    (out_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] st, input int r);
    exp_t e;
    int   rr;
    rr = (r > NR) ? NR : r;
    for (int k = 0; k < LANES; k++) e.state[128*k +: 128] = st[128*k +: 128] ^ rk[rr];
    e.round = 4'(rr);
    e.last  = (rr == NR);
    e.err   = 1'b0;
`ifdef ARK_ROUND_CHECK_EN
    if (r > NR) begin
      e.state = st;
      e.round = 4'(r);
      e.last  = 1'b0;
      e.err   = 1'b1;
    end
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_state();
    logic [W-1:0] s;
    for (int i = 0; i < W / 32; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic send(input logic [W-1:0] st, input logic auto_m, input logic [3:0] rnd,
                      input logic first, input exp_t e);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_state   = st;
    round_auto = auto_m;
    in_round   = rnd;
    in_first   = first;
    #1;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", budget);
    end else begin
      exp_q.push_back(e);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  // out_ready driver: random or forced, updated on the falling edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // monitor: a beat transfers on the next rising edge when valid and ready are both high
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_beat: got round %0d with empty scoreboard", out_round);
        end else begin
          e = exp_q.pop_front();
          check("beat_state", 256'(out_state), 256'(e.state));
          check("beat_round", 256'(out_round), 256'(e.round));
          check("beat_last", 256'(out_last), 256'(e.last));
`ifdef ARK_ROUND_CHECK_EN
          check("beat_err", 256'(out_err), 256'(e.err));
`endif
        end
      end
    end
  end

  initial begin
    logic [W-1:0] st_a;
    logic [W-1:0] st_b;
    exp_t         ea;
    exp_t         ef;
    int           budget;

    rst        = 1'b0;
    in_valid   = 1'b0;
    in_state   = '0;
    in_round   = '0;
    in_first   = 1'b0;
    round_auto = 1'b0;

    rk[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    for (int r = 1; r <= NR; r++) rk[r] = {16{8'(r * 17)}};
    key = '0;
    for (int r = 0; r <= NR; r++) key = {key[KW-129:0], rk[r]};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_out_valid", 256'(out_valid), 256'(0));
    check("reset_out_state", 256'(out_state), 256'(0));
    check("reset_out_round", 256'(out_round), 256'(0));
    check("reset_out_last", 256'(out_last), 256'(0));
    rst = 1'b1;

    // FIPS-197 appendix B round 0; lane 1 is zero so it yields the round key itself
    ef.state = {rk[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    ef.round = 4'd0;
    ef.last  = 1'b0;
    ef.err   = 1'b0;
    send({128'h0, 128'h3243f6a8885a308d313198a2e0370734}, 1'b0, 4'd0, 1'b0, ef);
    @(negedge clk);
    #1;
    check("fips_latency_valid", 256'(out_valid), 256'(1));
    check("fips_lane0", 256'(out_state[127:0]), 256'(128'h193de3bea0f4e22b9ac68d2ae9f84808));

    // auto rounds 0..10 then wrap to 0
    for (int i = 0; i < 12; i++)
      send('0, 1'b1, 4'd0, (i == 0), model('0, (i <= NR) ? i : 0));

    // manual beat in the middle of a block leaves the counter at 1
    st_a = rnd_state();
    send(st_a, 1'b0, 4'd5, 1'b0, model(st_a, 5));

    // backpressure: held beat uses round 1, stalled beat must use round 2
    repeat (2) @(posedge clk);
    ready_force = 1'b0;
    st_a = rnd_state();
    st_b = rnd_state();
    ea   = model(st_a, 1);
    send(st_a, 1'b1, 4'd0, 1'b0, ea);
    @(negedge clk);
    in_valid   = 1'b1;
    in_state   = st_b;
    round_auto = 1'b1;
    in_first   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", 256'(in_ready), 256'(0));
      check("stall_hold_state", 256'(out_state), 256'(ea.state));
      if (i == 4) ready_force = 1'b1;
      @(negedge clk);
    end
    #1;
    check("stall_release_ready", 256'(in_ready), 256'(1));
    exp_q.push_back(model(st_b, 2));
    @(posedge clk);
    #1 in_valid = 1'b0;

    // out-of-range manual rounds
    repeat (2) @(posedge clk);
    st_a = rnd_state();
    send(st_a, 1'b0, 4'd15, 1'b0, model(st_a, 15));
    st_a = rnd_state();
    send(st_a, 1'b0, 4'd11, 1'b0, model(st_a, 11));

    // reset while a beat is held: beat dropped, counter back to 0
    repeat (2) @(posedge clk);
    ready_force = 1'b0;
    st_a = rnd_state();
    send(st_a, 1'b1, 4'd0, 1'b0, model(st_a, 3));
    @(negedge clk);
    #1;
    check("rst_pre_valid", 256'(out_valid), 256'(1));
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_drop_valid", 256'(out_valid), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(1));
    exp_q.delete();
    rst = 1'b1;
    ready_force = 1'b1;
    st_a = rnd_state();
    send(st_a, 1'b1, 4'd0, 1'b0, model(st_a, 0));

    // random backpressure with manual rounds spanning the whole 4-bit range
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      r    = $urandom_range(0, 15);
      st_a = rnd_state();
      send(st_a, 1'b0, 4'(r), 1'b0, model(st_a, r));
    end
    rand_mode   = 1'b0;
    ready_force = 1'b1;

    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    check("drain_empty", 256'(exp_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
